// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory read port and decode output stream
//
// Ports (signals):
//   imem_addr   fetch -> memory  word address, equals the fetch PC
//   imem_rdata  memory -> fetch  read data, combinational on imem_addr
//   out_valid   fetch -> decode  queue head holds an instruction
//   out_ready   decode -> fetch  decode accepts the head this cycle
//   out_inst    fetch -> decode  head instruction word
//   out_pc      fetch -> decode  word address of out_inst
// Modports: master = fetch unit side, slave = memory/decode side.
interface if_fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 19
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with 2-entry queue, redirect and halt
//
// Ports:
//   clk             single clock, rising edge
//   rst_n           synchronous active-low reset
//   start           pulse, leaves IDLE and begins fetching at the current PC
//   redirect_valid  flush the queue and reload the PC from redirect_addr
//   redirect_addr   new word-address PC
//   halted          high while in HALTED
//   fetch_cnt       words enqueued since reset, wraps
//   bus             imem read port and decode stream (master side)
module if_fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 19,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_INST  = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  halted,
  output logic [31:0]           fetch_cnt,
  if_fetch_unit_if.master       bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [31:0]           fetch_cnt_q, fetch_cnt_d;
  logic [DATA_WIDTH-1:0] q_inst_q [2];
  logic [DATA_WIDTH-1:0] q_inst_d [2];
  logic [ADDR_WIDTH-1:0] q_pc_q [2];
  logic [ADDR_WIDTH-1:0] q_pc_d [2];

  logic do_push;
  logic do_pop;
  logic is_halt;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fetch_cnt_d = fetch_cnt_q;
    q_inst_d    = q_inst_q;
    q_pc_d      = q_pc_q;
    do_push     = 1'b0;
    do_pop      = (count_q != 2'd0) && bus.out_ready;
    is_halt     = (bus.imem_rdata == HALT_INST);

    if (redirect_valid) begin
      // Flush wins over everything; a same-cycle pop is simply absorbed by the flush.
      pc_d     = redirect_addr;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_FETCH;
        ST_HALTED: state_d = ST_FETCH;
        default:   ;
      endcase
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_FETCH;
        // Fetch only with a free slot as of this cycle; a pop in the same cycle
        // does not make room until the next one.
        ST_FETCH: do_push = (count_q != 2'd2);
        default:  ;
      endcase

      if (do_push) begin
        q_inst_d[wr_ptr_q] = bus.imem_rdata;
        q_pc_d[wr_ptr_q]   = pc_q;
        wr_ptr_d           = ~wr_ptr_q;
        fetch_cnt_d        = fetch_cnt_q + 32'd1;
        if (is_halt) begin
          // The halt word is delivered, but the PC stays on it.
          state_d = ST_HALTED;
        end else begin
          pc_d = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end

      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end

      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      fetch_cnt_q <= 32'd0;
      q_inst_q    <= '{default: '0};
      q_pc_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fetch_cnt_q <= fetch_cnt_d;
      q_inst_q    <= q_inst_d;
      q_pc_q      <= q_pc_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_inst  = q_inst_q[rd_ptr_q];
  assign bus.out_pc    = q_pc_q[rd_ptr_q];
  assign halted        = (state_q == ST_HALTED);
  assign fetch_cnt     = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
  localparam int          DW   = 32;
  localparam int          AW   = 19;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          halted;
  logic [31:0]   fetch_cnt;

  if_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  if_fetch_unit #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RESET_PC  ('0),
    .HALT_INST (HALT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .halted        (halted),
    .fetch_cnt     (fetch_cnt),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  // Sparse instruction memory; unwritten words return a non-halt pattern tagged with the address.
  logic [31:0] mem [int];
  int          mem_gen = 0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {8'hC0, 5'd0, a};
  endfunction

  task automatic mem_wr(input int a, input logic [31:0] d);
    mem[a] = d;
    mem_gen++;
  endtask

  always @(bus_if.imem_addr or mem_gen) bus_if.imem_rdata = mem_word(bus_if.imem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Holds reset for two rising edges; returns just after a falling edge with reset released.
  task automatic do_reset();
    rst_n          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0]   seq_w [4];
  logic [AW-1:0] exp_pc;
  logic [31:0]   exp_w;
  logic          running, done;
  logic          r_ready, r_redir, r_start;
  logic [AW-1:0] r_addr;
  int            pops;

  initial begin
    seq_w = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) mem_wr(i, seq_w[i]);

    // Reset state, then start with decode always ready
    do_reset();
    check_eq("rst_out_valid", bus_if.out_valid, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_imem_addr", bus_if.imem_addr, 0);
    check_eq("rst_fetch_cnt", fetch_cnt, 0);
    check_eq("rst_out_inst", bus_if.out_inst, 0);
    check_eq("rst_out_pc", bus_if.out_pc, 0);
    bus_if.out_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_eq("start_valid_latency", bus_if.out_valid, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      check_eq("stream_valid", bus_if.out_valid, 1);
      check_eq("stream_inst", bus_if.out_inst, seq_w[i]);
      check_eq("stream_pc", bus_if.out_pc, i);
      cyc();
    end

    // Backpressure: queue fills to two and fetching stalls
    do_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    check_eq("bp_valid", bus_if.out_valid, 1);
    check_eq("bp_fetch_cnt", fetch_cnt, 2);
    check_eq("bp_imem_addr", bus_if.imem_addr, 2);
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_inst", bus_if.out_inst, seq_w[i]);
      check_eq("bp_pc", bus_if.out_pc, i);
      cyc();
    end

    // Redirect with a full queue at PC=3
    do_reset();
    mem_wr(32'h100, 32'hAB);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    bus_if.out_ready = 1'b1;
    cyc();
    bus_if.out_ready = 1'b0;
    cyc();
    check_eq("rd_pre_addr", bus_if.imem_addr, 3);
    check_eq("rd_pre_head_pc", bus_if.out_pc, 1);
    redirect_valid = 1'b1;
    redirect_addr  = 19'h100;
    cyc();
    redirect_valid = 1'b0;
    check_eq("rd_flushed", bus_if.out_valid, 0);
    check_eq("rd_new_addr", bus_if.imem_addr, 19'h100);
    cyc();
    check_eq("rd_valid", bus_if.out_valid, 1);
    check_eq("rd_inst", bus_if.out_inst, 32'hAB);
    check_eq("rd_pc", bus_if.out_pc, 32'h100);
    check_eq("rd_fetch_cnt", fetch_cnt, 4);

    // Halt word at address 2
    mem_wr(2, HALT);
    do_reset();
    bus_if.out_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      exp_w = (i == 2) ? HALT : seq_w[i];
      check_eq("halt_inst", bus_if.out_inst, exp_w);
      check_eq("halt_pc", bus_if.out_pc, i);
      if (i == 2) check_eq("halt_flag", halted, 1);
      cyc();
    end
    cyc();
    check_eq("halt_drained", bus_if.out_valid, 0);
    check_eq("halt_still", halted, 1);
    check_eq("halt_addr", bus_if.imem_addr, 2);
    check_eq("halt_fetch_cnt", fetch_cnt, 3);
    redirect_valid = 1'b1;
    redirect_addr  = '0;
    cyc();
    redirect_valid = 1'b0;
    check_eq("halt_release", halted, 0);
    cyc();
    check_eq("halt_resume_valid", bus_if.out_valid, 1);
    check_eq("halt_resume_inst", bus_if.out_inst, 32'h11);
    mem_wr(2, 32'h33);

    // PC wrap, redirect issued while IDLE
    do_reset();
    mem_wr(32'h7FFFF, 32'h5);
    mem_wr(0, 32'h6);
    redirect_valid = 1'b1;
    redirect_addr  = 19'h7FFFF;
    cyc();
    redirect_valid = 1'b0;
    check_eq("wrap_idle_addr", bus_if.imem_addr, 19'h7FFFF);
    check_eq("wrap_idle_valid", bus_if.out_valid, 0);
    bus_if.out_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check_eq("wrap_inst0", bus_if.out_inst, 32'h5);
    check_eq("wrap_pc0", bus_if.out_pc, 19'h7FFFF);
    cyc();
    check_eq("wrap_inst1", bus_if.out_inst, 32'h6);
    check_eq("wrap_pc1", bus_if.out_pc, 0);
    mem_wr(0, 32'h11);

    // Reset with a full queue
    do_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    check_eq("mid_full_valid", bus_if.out_valid, 1);
    check_eq("mid_full_cnt", fetch_cnt, 2);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check_eq("mid_rst_valid", bus_if.out_valid, 0);
    check_eq("mid_rst_cnt", fetch_cnt, 0);
    check_eq("mid_rst_addr", bus_if.imem_addr, 0);
    bus_if.out_ready = 1'b1;
    repeat (3) cyc();
    check_eq("mid_idle_valid", bus_if.out_valid, 0);
    check_eq("mid_idle_cnt", fetch_cnt, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check_eq("mid_restart_valid", bus_if.out_valid, 1);
    check_eq("mid_restart_inst", bus_if.out_inst, 32'h11);

    // Randomized run against a stream model: after reset/redirect the delivered
    // sequence is mem[A], mem[A+1], ... up to and including the first halt word.
    mem.delete();
    mem_gen++;
    for (int i = 0; i < 64; i++) mem_wr(i, $urandom & 32'h7FFF_FFFF);
    mem_wr(25, HALT);
    mem_wr(47, HALT);
    do_reset();
    running = 1'b0;
    done    = 1'b0;
    exp_pc  = '0;
    pops    = 0;
    for (int c = 0; c < 4000; c++) begin
      r_ready = ($urandom_range(0, 9) < 7);
      r_redir = ($urandom_range(0, 19) == 0);
      r_start = ($urandom_range(0, 9) == 0);
      r_addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 63))
                                            : AW'(32'h7FFF0 + $urandom_range(0, 15));
      bus_if.out_ready = r_ready;
      redirect_valid   = r_redir;
      redirect_addr    = r_addr;
      start            = r_start;
      if (!running || done) begin
        check_eq("rnd_idle_valid", bus_if.out_valid, 0);
      end else if (bus_if.out_valid && r_ready) begin
        exp_w = mem_word(exp_pc);
        check_eq("rnd_pc", bus_if.out_pc, exp_pc);
        check_eq("rnd_inst", bus_if.out_inst, exp_w);
        if (exp_w == HALT) begin
          check_eq("rnd_halted", halted, 1);
          done = 1'b1;
        end
        exp_pc = exp_pc + 1'b1;
        pops++;
      end
      if (r_redir) begin
        exp_pc = r_addr;
        done   = 1'b0;
      end
      if (r_start) running = 1'b1;
      cyc();
    end
    check_eq("rnd_progress", (pops > 200), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage sitting directly downstream of the instruction memory. Drives the memory's combinational read address with a word-addressed PC and captures the returned word the same cycle. Buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake. Supports branch redirect/flush and halt detection.

Parameters:
DATA_WIDTH, 32, instruction word width (matches instruction memory data bus)
ADDR_WIDTH, 19, word-address width of instruction memory
RESET_PC, 0, PC value after reset
HALT_INST, 32'hFFFF_FFFF, encoding that stops fetching

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  pulse; leaves IDLE and begins fetching at current PC
imem_addr  output  ADDR_WIDTH  read address to instruction memory, equals PC register
imem_rdata  input  DATA_WIDTH  read data from instruction memory, valid combinationally in the same cycle
redirect_valid  input  1  branch/jump taken; flush queue and reload PC
redirect_addr  input  ADDR_WIDTH  new word-address PC
out_valid  output  1  queue head holds an instruction
out_ready  input  1  decode accepts head this cycle
out_inst  output  DATA_WIDTH  queue head instruction
out_pc  output  ADDR_WIDTH  word address of out_inst
halted  output  1  high in HALTED state
fetch_cnt  output  32  count of words enqueued since reset, wraps at 2^32

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE, PC=RESET_PC, queue count=0, rd/wr pointers=0, fetch_cnt=0. Outputs: out_valid=0, halted=0, imem_addr=RESET_PC; out_inst/out_pc=0. Reset mid-operation discards queue contents immediately.
- States: IDLE, FETCH, HALTED.
  - IDLE: no fetch. start=1 -> FETCH. redirect_valid in IDLE loads PC, stays IDLE.
  - FETCH: fetch when count<2 (decision never depends on out_ready). Fetch = enqueue {imem_rdata, PC}; PC <= (PC+1) mod 2^ADDR_WIDTH; fetch_cnt+1. If fetched word == HALT_INST: it is enqueued, PC not advanced, -> HALTED.
  - HALTED: no fetches; queue drains normally; halted=1. redirect_valid -> FETCH with new PC.
- Pop: out_valid && out_ready removes head. Push and pop in same cycle: count unchanged, both pointers advance.
- Queue full (count=2): no fetch even if a pop occurs this cycle; fetch resumes next cycle. Empty: out_valid=0, out_inst/out_pc hold last head value (don't-care).
- Redirect (highest priority after reset): at the edge, queue count=0, pointers cleared, PC=redirect_addr; no enqueue that cycle; a simultaneous pop is treated as accepted by decode (head was valid) but nothing else survives. First instruction from new PC is enqueued the following cycle, visible on out_valid one cycle later (redirect-to-out_valid latency 2 cycles).
- Fetch latency: word at PC enqueued at the edge it is addressed; out_valid rises the cycle after.
- Throughput: 1 instr/cycle sustained when out_ready held high (count toggles 1 and stays ≤2).
- PC wrap: PC=2^ADDR_WIDTH-1 fetches then wraps to 0.
- start while in FETCH/HALTED ignored.

Test Plan:
- Reset/start: preload mem[0..3]=0x11,0x22,0x33,0x44, hold rst_n=0 2 cycles, pulse start, out_ready=1 -> out_inst 0x11,0x22,0x33,0x44 on consecutive cycles, out_pc 0..3, first out_valid 2 cycles after start.
- Backpressure: out_ready=0 for 5 cycles after start -> count reaches 2, fetch_cnt=2, imem_addr stuck at 2; release -> 0x11,0x22,0x33 in order, none lost or duplicated.
- Redirect: mid-stream at PC=3 with 2 queued, redirect_valid=1, redirect_addr=0x100, mem[0x100]=0xAB -> queued words discarded, out_inst=0xAB with out_pc=0x100 two cycles later.
- Halt: mem[2]=0xFFFFFFFF -> words 0,1,2 delivered, halted=1, imem_addr holds 2, fetch_cnt=3; then redirect to 0 -> fetching resumes, halted=0.
- Wrap: redirect to 0x7FFFF, mem[0x7FFFF]=0x5, mem[0]=0x6 -> out_pc 0x7FFFF then 0x0000.
- Reset mid-operation: rst_n=0 with queue full -> next cycle out_valid=0, fetch_cnt=0, state IDLE, start required to resume.
